// File: rtl/capture_seq_pkg.sv
// -----------------------------------------------------------------------------
// capture_seq_pkg
// Shared definitions for the capture sequencer: the FSM state encoding, the
// vertical-timing register addresses written at the start of every frame, and
// the default gap and watchdog lengths.
// -----------------------------------------------------------------------------
package capture_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CFG1  = 3'd1,
      ST_CFG2  = 3'd2,
      ST_CFG3  = 3'd3,
      ST_TRIG  = 3'd4,
      ST_WAIT  = 3'd5,
      ST_GAP   = 3'd6,
      ST_DRAIN = 3'd7
   } state_t;

   // Shutter register addresses in the vertical timing FSM (MSB first).
   localparam logic [1:0] REG_SHUT_HI  = 2'd1;
   localparam logic [1:0] REG_SHUT_MID = 2'd2;
   localparam logic [1:0] REG_SHUT_LO  = 2'd3;

   // Idle cycles between frames and readout watchdog limit, in clk cycles.
   localparam logic [15:0] GAP_CYC_DEF  = 16'd300;
   localparam logic [15:0] WDOG_CYC_DEF = 16'd8192;

endpackage

// File: rtl/capture_seq_edge_det.sv
// -----------------------------------------------------------------------------
// capture_seq_edge_det
// Rising-edge detector built on a registered copy of the input.
//   clk   in   clock
//   rst   in   asynchronous active-low reset
//   din   in   level to watch
//   rise  out  high for the cycle in which din is 1 and was 0 on the last edge
// -----------------------------------------------------------------------------
module capture_seq_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise
);

   logic prev_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev_reg <= 1'b0;
      end else begin
         prev_reg <= din;
      end
   end

   assign rise = din & ~prev_reg;

endmodule

// File: rtl/capture_seq.sv
// -----------------------------------------------------------------------------
// capture_seq
// Burst capture sequencer. On start it latches the exposure time and frame
// count, then for every frame writes the three shutter registers of the
// vertical timing FSM, fires a one-cycle trigger, waits for the end-of-frame
// edge on vdone (with a watchdog on vact activity), and idles GAP_CYC cycles
// before the next frame.
//   clk         in   pixel clock
//   rst         in   asynchronous active-low reset
//   start       in   begin a burst (accepted in IDLE only, not with abort)
//   abort       in   stop the burst
//   shutter     in   exposure time, 125 us units
//   nframes     in   frames per burst (0 means 1)
//   cfg_a/d/we  out  register write port to the vertical timing FSM
//   trigger     out  frame trigger
//   vact        in   line-active level from the vertical timing FSM
//   vdone       in   frame-done level from the vertical timing FSM
//   busy        out  sequencer not idle
//   frame_idx   out  frames completed in the current burst
//   frame_done  out  pulse per completed frame
//   burst_done  out  pulse when a burst finishes normally
//   err_wdog    out  sticky watchdog error, cleared by the next start
// -----------------------------------------------------------------------------
module capture_seq
   import capture_seq_pkg::*;
#(
   parameter logic [15:0] GAP_CYC  = GAP_CYC_DEF,
   parameter logic [15:0] WDOG_CYC = WDOG_CYC_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   input  logic [23:0] shutter,
   input  logic [7:0]  nframes,
   output logic [1:0]  cfg_a,
   output logic [7:0]  cfg_d,
   output logic        cfg_we,
   output logic        trigger,
   input  logic        vact,
   input  logic        vdone,
   output logic        busy,
   output logic [7:0]  frame_idx,
   output logic        frame_done,
   output logic        burst_done,
   output logic        err_wdog
);

   state_t      state_reg;
   logic [23:0] shutter_reg;
   logic [7:0]  nframes_reg;
   logic [15:0] gap_cnt_reg;
   logic [15:0] wdog_cnt_reg;
   logic        wdog_armed_reg;

   logic        vdone_rise;
   logic        vact_rise;
   logic [7:0]  idx_inc;
   logic        last_frame;
   logic        wdog_expired;

   capture_seq_edge_det u_vdone_edge (
      .clk  (clk),
      .rst  (rst),
      .din  (vdone),
      .rise (vdone_rise)
   );

   capture_seq_edge_det u_vact_edge (
      .clk  (clk),
      .rst  (rst),
      .din  (vact),
      .rise (vact_rise)
   );

   // frame_idx < nframes_reg <= 255 whenever this is used, so no wrap.
   assign idx_inc    = frame_idx + 8'd1;
   assign last_frame = !(idx_inc < nframes_reg);

   // Only a timer that has seen vact activity can expire; any edge this
   // cycle counts as activity and takes priority.
   assign wdog_expired = wdog_armed_reg && !vact_rise && !vdone_rise &&
                         (wdog_cnt_reg == WDOG_CYC - 16'd1);

   assign busy = (state_reg != ST_IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg      <= ST_IDLE;
         shutter_reg    <= 24'd0;
         nframes_reg    <= 8'd0;
         gap_cnt_reg    <= 16'd0;
         wdog_cnt_reg   <= 16'd0;
         wdog_armed_reg <= 1'b0;
         cfg_a          <= 2'd0;
         cfg_d          <= 8'd0;
         cfg_we         <= 1'b0;
         trigger        <= 1'b0;
         frame_idx      <= 8'd0;
         frame_done     <= 1'b0;
         burst_done     <= 1'b0;
         err_wdog       <= 1'b0;
      end else begin
         // Strobes are asserted only on the transition into their state.
         cfg_we     <= 1'b0;
         trigger    <= 1'b0;
         frame_done <= 1'b0;
         burst_done <= 1'b0;

         // Watchdog runs while waiting for end of frame, including DRAIN.
         if (state_reg == ST_WAIT || state_reg == ST_DRAIN) begin
            if (vact_rise) begin
               wdog_armed_reg <= 1'b1;
               wdog_cnt_reg   <= 16'd0;
            end else if (wdog_armed_reg) begin
               wdog_cnt_reg <= wdog_cnt_reg + 16'd1;
            end
         end

         case (state_reg)
            ST_IDLE: begin
               if (start && !abort) begin
                  shutter_reg <= shutter;
                  nframes_reg <= (nframes == 8'd0) ? 8'd1 : nframes;
                  frame_idx   <= 8'd0;
                  err_wdog    <= 1'b0;
                  state_reg   <= ST_CFG1;
                  cfg_we      <= 1'b1;
                  cfg_a       <= REG_SHUT_HI;
                  cfg_d       <= shutter[23:16];
               end
            end

            ST_CFG1: begin
               if (abort) begin
                  state_reg <= ST_IDLE;
               end else begin
                  state_reg <= ST_CFG2;
                  cfg_we    <= 1'b1;
                  cfg_a     <= REG_SHUT_MID;
                  cfg_d     <= shutter_reg[15:8];
               end
            end

            ST_CFG2: begin
               if (abort) begin
                  state_reg <= ST_IDLE;
               end else begin
                  state_reg <= ST_CFG3;
                  cfg_we    <= 1'b1;
                  cfg_a     <= REG_SHUT_LO;
                  cfg_d     <= shutter_reg[7:0];
               end
            end

            ST_CFG3: begin
               if (abort) begin
                  state_reg <= ST_IDLE;
               end else begin
                  state_reg <= ST_TRIG;
                  trigger   <= 1'b1;
               end
            end

            ST_TRIG: begin
               if (abort) begin
                  state_reg <= ST_IDLE;
               end else begin
                  // Exposure before the first vact edge is not timed.
                  state_reg      <= ST_WAIT;
                  wdog_armed_reg <= 1'b0;
                  wdog_cnt_reg   <= 16'd0;
               end
            end

            ST_WAIT: begin
               if (vdone_rise) begin
                  frame_idx  <= idx_inc;
                  frame_done <= 1'b1;
                  if (abort || last_frame) begin
                     state_reg  <= ST_IDLE;
                     burst_done <= !abort;
                  end else begin
                     state_reg   <= ST_GAP;
                     gap_cnt_reg <= 16'd0;
                  end
               end else if (wdog_expired) begin
                  err_wdog  <= 1'b1;
                  state_reg <= ST_IDLE;
               end else if (abort) begin
                  state_reg <= ST_DRAIN;
               end
            end

            ST_DRAIN: begin
               if (vdone_rise) begin
                  frame_idx  <= idx_inc;
                  frame_done <= 1'b1;
                  state_reg  <= ST_IDLE;
               end else if (wdog_expired) begin
                  err_wdog  <= 1'b1;
                  state_reg <= ST_IDLE;
               end
            end

            ST_GAP: begin
               if (abort) begin
                  state_reg <= ST_IDLE;
               end else if ((gap_cnt_reg + 16'd1) >= GAP_CYC) begin
                  state_reg <= ST_CFG1;
                  cfg_we    <= 1'b1;
                  cfg_a     <= REG_SHUT_HI;
                  cfg_d     <= shutter_reg[23:16];
               end else begin
                  gap_cnt_reg <= gap_cnt_reg + 16'd1;
               end
            end

            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
